vmem_seq: RTL and testbench

Multi-beat vector load/store sequencer that sits directly upstream of the data memory in the execution datapath. It accepts one vector memory operation (base, stride, element count, mask, store data) and drives the four DMEM lane ports (addresses, per-lane write/read enables, write data) one beat of four 32-bit elements per cycle. For loads it gathers the lane read data into a VLEN-wide write-back word for the vector register file. It replaces the single-cycle, fixed-four-element lane drive so VLEN greater than 128 and strided access work.

---
 rtl/vmem_seq.sv | 114 +++++++++++
 tb/tb_vmem_seq.sv | 138 +++++++++++++
 2 files changed

// File: rtl/vmem_seq.sv
// vmem_seq: multi-beat vector load/store sequencer driving four DMEM lanes (VMEM_SEQ_STRIDE_EN enables strided addressing)
module vmem_seq #(
  parameter int VLEN = 128,
  parameter int XLEN = 32,
  localparam int ELEMS = VLEN / 32,
  localparam int VLW = $clog2(ELEMS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              isStore,
  input  logic [XLEN-1:0]   base,
  input  logic [XLEN-1:0]   stride,
  input  logic [VLW-1:0]    vl,
  input  logic [ELEMS-1:0]  vmask,
  input  logic [VLEN-1:0]   vs3,
  input  logic [VLEN-1:0]   vdOld,
  input  logic [127:0]      memRData,
  output logic [XLEN-1:0]   addr0,
  output logic [XLEN-1:0]   addr1,
  output logic [XLEN-1:0]   addr2,
  output logic [XLEN-1:0]   addr3,
  output logic [2:0]        we0,
  output logic [2:0]        we1,
  output logic [2:0]        we2,
  output logic [2:0]        we3,
  output logic [2:0]        re0,
  output logic [2:0]        re1,
  output logic [2:0]        re2,
  output logic [2:0]        re3,
  output logic [127:0]      memWData,
  output logic [VLEN-1:0]   vwb,
  output logic              busy,
  output logic              done
);
  localparam int BEATS = ELEMS / 4;
  localparam int BW = $clog2(BEATS + 1);
  localparam logic [2:0] WCODE = 3'b010;
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
  state_t state;
  logic st_r, last;
  logic [XLEN-1:0] ra, str;
  logic [BW-1:0] b;
  logic [VLW-1:0] vl_r, vl_c;
  logic [ELEMS-1:0] mask_r;
  logic [3:0] msk_sh, act;
  logic [VLEN-1:0] vs3_r, wmask;
  logic [127:0] vs3_sh, lwd, lm;
  logic [3:0][XLEN-1:0] la;
  logic [3:0][2:0] lwe, lre;
`ifdef VMEM_SEQ_STRIDE_EN
  logic [XLEN-1:0] stride_r;
  always_ff @(posedge clk or posedge rst)
    if (rst) stride_r <= '0;
    else if (state == IDLE && start) stride_r <= stride;
  assign str = stride_r;
`else
  logic unused_stride;
  assign unused_stride = ^stride;
  assign str = XLEN'(4);
`endif
  always_comb begin
    vl_c = vl > VLW'(ELEMS) ? VLW'(ELEMS) : vl;
    msk_sh = 4'(mask_r >> {b, 2'b00});
    vs3_sh = 128'(vs3_r >> {b, 7'd0});
    last = (32'(b) + 32'd1) * 32'd4 >= 32'(vl_r);
    for (int k = 0; k < 4; k++) begin
      act[k] = state == ISSUE && 32'(b) * 32'd4 + 32'(k) < 32'(vl_r) && msk_sh[k];
      la[k] = act[k] ? ra + XLEN'(k) * str : '0;
      lwe[k] = act[k] && st_r ? WCODE : 3'b000;
      lre[k] = act[k] && !st_r ? WCODE : 3'b000;
      lwd[32*k +: 32] = act[k] && st_r ? vs3_sh[32*k +: 32] : 32'd0;
      lm[32*k +: 32] = {32{act[k] && !st_r}};
    end
    wmask = VLEN'(lm) << {b, 7'd0};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      st_r <= 1'b0;
      ra <= '0;
      b <= '0;
      vl_r <= '0;
      mask_r <= '0;
      vs3_r <= '0;
      vwb <= '0;
    end else
      case (state)
        IDLE:
          if (start) begin
            st_r <= isStore;
            ra <= base;
            b <= '0;
            vl_r <= vl_c;
            mask_r <= vmask;
            vs3_r <= vs3;
            vwb <= vdOld;
            state <= vl_c == '0 ? DONE : ISSUE;
          end
        ISSUE: begin
          vwb <= (vwb & ~wmask) | ({BEATS{memRData}} & wmask);
          ra <= ra + (str << 2);
          b <= b + 1'b1;
          state <= last ? DONE : ISSUE;
        end
        default: state <= IDLE;
      endcase
  assign {addr3, addr2, addr1, addr0} = la;
  assign {we3, we2, we1, we0} = lwe;
  assign {re3, re2, re1, re0} = lre;
  assign memWData = lwd;
  assign busy = state != IDLE;
  assign done = state == DONE;
endmodule

// File: tb/tb_vmem_seq.sv
// tb_vmem_seq: randomized self-checking bench for vmem_seq against an element-level reference model
module tb_vmem_seq;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, isStore = 1'b0;
  logic [31:0] base = '0, stride = '0;
  logic [3:0] vl = '0;
  logic [7:0] vmask = '0;
  logic [255:0] vs3 = '0, vdOld = '0, vwb;
  logic [127:0] memRData = '0, memWData;
  logic [31:0] addr0, addr1, addr2, addr3;
  logic [2:0] we0, we1, we2, we3, re0, re1, re2, re3;
  logic busy, done;
  int errs = 0, checks = 0;
  vmem_seq #(.VLEN(256), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .isStore(isStore), .base(base), .stride(stride),
    .vl(vl), .vmask(vmask), .vs3(vs3), .vdOld(vdOld), .memRData(memRData),
    .addr0(addr0), .addr1(addr1), .addr2(addr2), .addr3(addr3),
    .we0(we0), .we1(we1), .we2(we2), .we3(we3), .re0(re0), .re1(re1), .re2(re2), .re3(re3),
    .memWData(memWData), .vwb(vwb), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction
  task automatic run_op(input bit st, input logic [31:0] b0, input logic [31:0] s, input logic [3:0] l,
                        input logic [7:0] m, input logic [255:0] d, input logic [255:0] old, input bit spam);
    logic [31:0] sv;
    logic [255:0] ewb;
    logic [127:0] ea, ewd, rd;
    logic [11:0] ewe, ere;
    int vlc, nb, e;
    bit a;
    @(negedge clk);
    start = 1'b1; isStore = st; base = b0; stride = s; vl = l; vmask = m; vs3 = d; vdOld = old;
`ifdef VMEM_SEQ_STRIDE_EN
    sv = s;
`else
    sv = 32'd4;
`endif
    vlc = l > 8 ? 8 : int'(l);
    nb = (vlc + 3) / 4;
    ewb = old;
    for (int j = 0; j < nb; j++) begin
      @(negedge clk);
      if (spam) begin
        base = $urandom; stride = $urandom; vl = 4'($urandom); vmask = 8'($urandom);
        vs3 = rnd256(); isStore = 1'($urandom);
      end else start = 1'b0;
      rd = 128'(rnd256());
      memRData = rd;
      for (int k = 0; k < 4; k++) begin
        e = 4 * j + k;
        a = e < vlc && m[e];
        ea[32*k +: 32] = a ? b0 + e * sv : 32'd0;
        ewe[3*k +: 3] = a && st ? 3'b010 : 3'b000;
        ere[3*k +: 3] = a && !st ? 3'b010 : 3'b000;
        ewd[32*k +: 32] = a && st ? d[32*e +: 32] : 32'd0;
        if (a && !st) ewb[32*e +: 32] = rd[32*k +: 32];
      end
      #1;
      chk("addr", {addr3, addr2, addr1, addr0}, ea);
      chk("we", {we3, we2, we1, we0}, ewe);
      chk("re", {re3, re2, re1, re0}, ere);
      chk("wdata", memWData, ewd);
      chk("beat_busy", busy, 1);
      chk("beat_done", done, 0);
    end
    @(negedge clk);
    start = 1'b0;
    memRData = 128'(rnd256());
    #1;
    chk("done", done, 1);
    chk("done_busy", busy, 1);
    chk("done_en", {we3, we2, we1, we0, re3, re2, re1, re0}, 0);
    chk("vwb", vwb, ewb);
    @(negedge clk);
    #1;
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("vwb_hold", vwb, ewb);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_vwb", vwb, 0);
    chk("rst_en", {we3, we2, we1, we0, re3, re2, re1, re0}, 0);
    rst = 1'b0;
    run_op(0, 32'h100, 32'd4, 4'd4, 8'h0F, rnd256(), rnd256(), 0);
    run_op(1, 32'h40, 32'h20, 4'd6, 8'hFF, rnd256(), rnd256(), 0);
    run_op(0, 32'h200, 32'd4, 4'd4, 8'b0101, rnd256(), {8{32'hAAAAAAAA}}, 0);
    run_op(0, 32'h300, 32'd8, 4'd0, 8'hFF, rnd256(), rnd256(), 0);
    run_op(0, 32'hFFFFFFF8, 32'd4, 4'd4, 8'hFF, rnd256(), rnd256(), 0);
    @(negedge clk);
    start = 1'b1; isStore = 1'b1; base = 32'h40; stride = 32'h20; vl = 4'd6; vmask = 8'hFF; vs3 = rnd256();
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("mid_we", {we3, we2, we1, we0}, 12'b010_010_010_010);
    chk("mid_busy", busy, 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_en", {we3, we2, we1, we0, re3, re2, re1, re0}, 0);
    chk("arst_addr", {addr3, addr2, addr1, addr0}, 0);
    chk("arst_wdata", memWData, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_vwb", vwb, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      #1;
      chk("post_rst_done", done, 0);
      chk("post_rst_busy", busy, 0);
    end
    run_op(1, 32'h1000, 32'h10, 4'd8, 8'hFF, rnd256(), rnd256(), 1);
    run_op(0, 32'h2000, 32'hC, 4'd12, 8'hF7, rnd256(), rnd256(), 1);
    run_op(0, 32'h3000, 32'h4, 4'd15, 8'hFF, rnd256(), rnd256(), 0);
    for (int i = 0; i < 25; i++)
      run_op(1'($urandom), $urandom, $urandom, 4'($urandom), 8'($urandom), rnd256(), rnd256(), 1'($urandom));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
